// File: rtl/ahb_img_mem_pkg.sv
// Shared AHB-Lite encodings, data-phase state encoding and lane/alignment helpers
// for the image memory slave.
package ahb_img_mem_pkg;

    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DONE = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    // Little-endian byte lanes touched by an access of this size at this address.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        case (size)
            HSIZE_BYTE: lane_mask = 4'b0001 << a;
            HSIZE_HALF: lane_mask = a[1] ? 4'b1100 : 4'b0011;
            default:    lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic size_err(input logic [2:0] size, input logic [1:0] a);
        size_err = (size > HSIZE_WORD)
                || (size == HSIZE_HALF && a[0])
                || (size == HSIZE_WORD && a != 2'b00);
    endfunction

endpackage

// File: rtl/ahb_img_mem_sram.sv
// 1R1W synchronous word RAM with per-byte write enables and a registered read port.
module img_sram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/ahb_img_mem.sv
// AHB-Lite image memory slave with programmable wait states, per-lane write bypass
// into the read path, and a single-master bus grant with fixed latency.
module ahb_img_mem
    import ahb_img_mem_pkg::*;
#(
    parameter logic [31:0] BASE      = 32'h0000_0000,
    parameter int          ADDR_W    = 12,
    parameter int          WAIT_NS   = 1,
    parameter int          WAIT_SEQ  = 0,
    parameter int          GRANT_LAT = 2
) (
    input  logic        I_HCLK,
    input  logic        I_HRESET,
    input  logic        I_HBUSREQ,
    input  logic        I_HSEL,
    input  logic [31:0] I_HADDR,
    input  logic [1:0]  I_HTRANS,
    input  logic [2:0]  I_HSIZE,
    input  logic [2:0]  I_HBURST,
    input  logic        I_HWRITE,
    input  logic [31:0] I_HWDATA,
    output logic        O_HGRANT,
    output logic [31:0] O_HRDATA,
    output logic        O_HREADY,
    output logic [1:0]  O_HRESP,
    output logic [2:0]  O_STATE
);

    localparam logic [3:0] NS_WAITS  = 4'(WAIT_NS);
    localparam logic [3:0] SEQ_WAITS = 4'(WAIT_SEQ);
    localparam logic [2:0] GL        = 3'(GRANT_LAT);

    state_t            state, state_n;
    logic [3:0]        wcnt, wcnt_n;
    logic [ADDR_W-1:0] p_word;
    logic              p_write;
    logic [3:0]        p_be, p_n;
    logic [31:0]       off;
    logic [ADDR_W-1:0] dec_word, raddr;
    logic [3:0]        dec_n;
    logic              dec_err, accept, we;
    logic [31:0]       ram_q, byp_data;
    logic [3:0]        byp_be;
    logic              byp_hit;
    logic [2:0]        gcnt;
    logic              unused_burst;

    // Valid/ready: an address phase is taken only on a cycle where O_HREADY=1 and
    // HSEL with a NONSEQ/SEQ transfer is presented; its data phase ends on the next
    // cycle with O_HREADY=1. The master must hold the address while O_HREADY=0.
    assign unused_burst = ^I_HBURST;
    assign off      = I_HADDR - BASE;
    assign dec_word = off[ADDR_W+1:2];
    assign dec_err  = ((off >> (ADDR_W + 2)) != '0) || size_err(I_HSIZE, I_HADDR[1:0]);
    assign dec_n    = (I_HTRANS == HTRANS_SEQ) ? SEQ_WAITS : NS_WAITS;

    assign O_HREADY = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR2);
    assign O_HRESP  = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign O_STATE  = state;
    assign accept   = I_HSEL && I_HTRANS[1] && O_HREADY;
    assign we       = (state == ST_DONE) && p_write && !I_HRESET;
    // A zero-wait beat needs its RAM read launched with the address phase itself.
    assign raddr    = accept ? dec_word : p_word;

    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        case (state)
            ST_WAIT: begin
                if (wcnt >= p_n) state_n = ST_DONE;
                else             wcnt_n  = wcnt + 4'd1;
            end
            ST_ERR1: state_n = ST_ERR2;
            default: begin
                state_n = ST_IDLE;
                if (accept) begin
                    if (dec_err)             state_n = ST_ERR1;
                    else if (dec_n == 4'd0)  state_n = ST_DONE;
                    else begin
                        state_n = ST_WAIT;
                        wcnt_n  = 4'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            state    <= ST_IDLE;
            wcnt     <= '0;
            p_word   <= '0;
            p_write  <= 1'b0;
            p_be     <= '0;
            p_n      <= '0;
            byp_hit  <= 1'b0;
            byp_be   <= '0;
            byp_data <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            if (accept) begin
                p_word  <= dec_word;
                p_write <= I_HWRITE;
                p_be    <= lane_mask(I_HSIZE, I_HADDR[1:0]);
                p_n     <= dec_n;
            end
            // The RAM read on this edge misses a write committed on the same edge.
            byp_hit  <= we && (p_word == raddr);
            byp_be   <= p_be;
            byp_data <= I_HWDATA;
        end
    end

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET || !I_HBUSREQ) begin
            gcnt     <= '0;
            O_HGRANT <= 1'b0;
        end else if (gcnt != GL) begin
            gcnt     <= gcnt + 3'd1;
            O_HGRANT <= (gcnt + 3'd1 == GL);
        end
    end

    img_sram #(.ADDR_W(ADDR_W)) u_sram (
        .clk   (I_HCLK),
        .we    (we),
        .waddr (p_word),
        .be    (p_be),
        .wdata (I_HWDATA),
        .raddr (raddr),
        .rdata (ram_q)
    );

    always_comb begin
        O_HRDATA = '0;
        if (state == ST_DONE && !p_write) begin
            for (int i = 0; i < 4; i++) begin
                O_HRDATA[8*i +: 8] = (byp_hit && byp_be[i]) ? byp_data[8*i +: 8] : ram_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_img_mem.sv
// Bench for ahb_img_mem: three instances (1/0, 0/0 and 3/0 NONSEQ/SEQ waits) behind
// one pipelined master, checked against constants and a word-array memory model.
`timescale 1ns/1ps
module tb_ahb_img_mem;

  localparam int ADDR_W = 12;
  localparam logic [31:0] LIMIT = 32'(4 * (2**ADDR_W));

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, busreq = 1'b1, hsel = 1'b0, hwrite = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [1:0] htrans = 2'b00;
  logic [2:0] hsize = 3'b010, hburst = 3'b000;
  int which = 0;
  int ns_of[3]  = '{1, 0, 3};
  int seq_of[3] = '{0, 0, 0};

  logic hsel_a, hsel_z, hsel_w;
  logic grant_a, grant_z, grant_w, ready_a, ready_z, ready_w;
  logic [31:0] rdata_a, rdata_z, rdata_w;
  logic [1:0] resp_a, resp_z, resp_w;
  logic [2:0] st_a, st_z, st_w;
  logic hgrant, hready;
  logic [31:0] hrdata;
  logic [1:0] hresp;

  always_comb begin
    hsel_a = hsel && (which == 0);
    hsel_z = hsel && (which == 1);
    hsel_w = hsel && (which == 2);
    case (which)
      1:       begin hgrant = grant_z; hready = ready_z; hrdata = rdata_z; hresp = resp_z; end
      2:       begin hgrant = grant_w; hready = ready_w; hrdata = rdata_w; hresp = resp_w; end
      default: begin hgrant = grant_a; hready = ready_a; hrdata = rdata_a; hresp = resp_a; end
    endcase
  end

  ahb_img_mem #(.BASE(32'h0), .ADDR_W(ADDR_W), .WAIT_NS(1), .WAIT_SEQ(0), .GRANT_LAT(2)) dut (
    .I_HCLK(clk), .I_HRESET(rst), .I_HBUSREQ(busreq), .I_HSEL(hsel_a), .I_HADDR(haddr),
    .I_HTRANS(htrans), .I_HSIZE(hsize), .I_HBURST(hburst), .I_HWRITE(hwrite), .I_HWDATA(hwdata),
    .O_HGRANT(grant_a), .O_HRDATA(rdata_a), .O_HREADY(ready_a), .O_HRESP(resp_a), .O_STATE(st_a));

  ahb_img_mem #(.BASE(32'h0), .ADDR_W(ADDR_W), .WAIT_NS(0), .WAIT_SEQ(0), .GRANT_LAT(2)) dut_z (
    .I_HCLK(clk), .I_HRESET(rst), .I_HBUSREQ(busreq), .I_HSEL(hsel_z), .I_HADDR(haddr),
    .I_HTRANS(htrans), .I_HSIZE(hsize), .I_HBURST(hburst), .I_HWRITE(hwrite), .I_HWDATA(hwdata),
    .O_HGRANT(grant_z), .O_HRDATA(rdata_z), .O_HREADY(ready_z), .O_HRESP(resp_z), .O_STATE(st_z));

  ahb_img_mem #(.BASE(32'h0), .ADDR_W(ADDR_W), .WAIT_NS(3), .WAIT_SEQ(0), .GRANT_LAT(2)) dut_w (
    .I_HCLK(clk), .I_HRESET(rst), .I_HBUSREQ(busreq), .I_HSEL(hsel_w), .I_HADDR(haddr),
    .I_HTRANS(htrans), .I_HSIZE(hsize), .I_HBURST(hburst), .I_HWRITE(hwrite), .I_HWDATA(hwdata),
    .O_HGRANT(grant_w), .O_HRDATA(rdata_w), .O_HREADY(ready_w), .O_HRESP(resp_w), .O_STATE(st_w));

  // ---------------- transfer tables / scoreboard ----------------
  logic [31:0] t_addr[32], t_data[32], r_data[32];
  logic [2:0]  t_size[32];
  logic [1:0]  t_trans[32], r_resp[32];
  logic        t_wr[32];
  logic        rdy_log[$], exp_rdy[$];
  logic [31:0] exp_q[$];
  logic [31:0] model[int];
  int total = 0, bad = 0;

  initial begin
    #800000;
    $display("FAIL watchdog: sim time expired, required finish before 800000ns");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic is_err(input logic [31:0] a, input logic [2:0] s);
    return (a >= LIMIT) || (s > 3'd2) || ((a % (32'd1 << s)) != 32'd0);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [31:0] a, input logic [2:0] s);
    int first, nbytes;
    logic [31:0] res;
    res = old;
    first = int'(a % 32'd4);
    nbytes = 1 << s;
    for (int k = first; k < first + nbytes; k++) res[8*k +: 8] = d[8*k +: 8];
    return res;
  endfunction

  task automatic build_exp_rdy(input int n, input int inst);
    int w;
    exp_rdy.delete();
    for (int i = 0; i < n; i++) begin
      if (is_err(t_addr[i], t_size[i])) begin
        exp_rdy.push_back(1'b0);
        exp_rdy.push_back(1'b1);
      end else begin
        w = (t_trans[i] == 2'b11) ? seq_of[inst] : ns_of[inst];
        repeat (w) exp_rdy.push_back(1'b0);
        exp_rdy.push_back(1'b1);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic set_beat(input int i, input logic [31:0] a, input logic w, input logic [2:0] s,
                          input logic [1:0] tr, input logic [31:0] d);
    t_addr[i] = a; t_wr[i] = w; t_size[i] = s; t_trans[i] = tr; t_data[i] = d;
  endtask

  task automatic drive_addr(input int ai, input int n);
    if (ai < n) begin
      hsel = 1'b1; haddr = t_addr[ai]; htrans = t_trans[ai];
      hsize = t_size[ai]; hwrite = t_wr[ai]; hburst = 3'b011;
    end else begin
      hsel = 1'b0; haddr = '0; htrans = 2'b00; hsize = 3'b010; hwrite = 1'b0;
    end
  endtask

  // Called at posedge+1; runs n beats as a pipelined master, returns at posedge+1.
  task automatic run_xfers(input int n);
    int ai, di, cyc;
    logic rdy;
    logic [1:0] rsp;
    logic [31:0] rd;
    ai = 0; di = -1; cyc = 0;
    rdy_log.delete();
    drive_addr(ai, n);
    hwdata = '0;
    while ((ai < n || di >= 0) && cyc < 200) begin
      @(negedge clk);
      rdy = hready; rsp = hresp; rd = hrdata;
      if (di >= 0) rdy_log.push_back(rdy);
      @(posedge clk); #1;
      if (rdy) begin
        if (di >= 0) begin r_data[di] = rd; r_resp[di] = rsp; end
        if (ai < n) begin di = ai; ai++; end else di = -1;
      end
      drive_addr(ai, n);
      hwdata = (di >= 0 && t_wr[di]) ? t_data[di] : 32'h0;
      cyc++;
    end
    total++;
    if (cyc >= 200) begin
      bad++;
      $display("FAIL xfer_timeout: beats unfinished=%0d required 0", n - ai);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    which = 0; rst = 1'b1; busreq = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (hgrant !== 1'b0) begin bad++; $display("FAIL rst_grant: got %b want 0", hgrant); end
    total++; if (hready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", hready); end
    total++; if (hresp !== 2'b00) begin bad++; $display("FAIL rst_resp: got %b want 00", hresp); end
    total++; if (hrdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", hrdata); end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    total++; if (hgrant !== 1'b0) begin bad++; $display("FAIL grant_c1: got %b want 0", hgrant); end
    @(negedge clk);
    total++; if (hgrant !== 1'b1) begin bad++; $display("FAIL grant_c2: got %b want 1", hgrant); end
    @(posedge clk); #1 busreq = 1'b0;
    @(posedge clk); @(negedge clk);
    total++; if (hgrant !== 1'b0) begin bad++; $display("FAIL grant_drop: got %b want 0", hgrant); end
    @(posedge clk); #1 busreq = 1'b1;
  endtask

  task automatic test_burst();
    which = 0;
    for (int i = 0; i < 4; i++)
      set_beat(i, 32'h10 + 32'(4*i), 1'b1, 3'b010, (i == 0) ? 2'b10 : 2'b11, 32'(i + 1));
    run_xfers(4);
    build_exp_rdy(4, 0);
    total++;
    if (rdy_log.size() != exp_rdy.size()) begin
      bad++; $display("FAIL burst_wr_len: got %0d want %0d", rdy_log.size(), exp_rdy.size());
    end else foreach (exp_rdy[k]) begin
      total++;
      if (rdy_log[k] !== exp_rdy[k]) begin bad++; $display("FAIL burst_wr_ready[%0d]: got %b want %b", k, rdy_log[k], exp_rdy[k]); end
    end
    for (int i = 0; i < 4; i++) t_wr[i] = 1'b0;
    run_xfers(4);
    total++;
    if (rdy_log.size() != exp_rdy.size()) begin
      bad++; $display("FAIL burst_rd_len: got %0d want %0d", rdy_log.size(), exp_rdy.size());
    end else foreach (exp_rdy[k]) begin
      total++;
      if (rdy_log[k] !== exp_rdy[k]) begin bad++; $display("FAIL burst_rd_ready[%0d]: got %b want %b", k, rdy_log[k], exp_rdy[k]); end
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (r_data[i] !== 32'(i + 1)) begin bad++; $display("FAIL burst_rd_data[%0d]: got %h want %h", i, r_data[i], 32'(i + 1)); end
    end
  endtask

  task automatic test_lanes();
    which = 0;
    set_beat(0, 32'h20, 1'b1, 3'b010, 2'b10, 32'h0);
    set_beat(1, 32'h21, 1'b1, 3'b000, 2'b10, 32'h0000_AA00);
    set_beat(2, 32'h22, 1'b1, 3'b001, 2'b10, 32'hBEEF_0000);
    set_beat(3, 32'h20, 1'b0, 3'b010, 2'b10, 32'h0);
    run_xfers(4);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (r_resp[i] !== 2'b00) begin bad++; $display("FAIL lanes_resp[%0d]: got %b want 00", i, r_resp[i]); end
    end
    total++;
    if (r_data[3] !== 32'hBEEF_AA00) begin bad++; $display("FAIL lanes_data: got %h want beefaa00", r_data[3]); end
  endtask

  task automatic test_bypass();
    which = 1;
    set_beat(0, 32'h40, 1'b1, 3'b010, 2'b10, 32'hCAFE_F00D);
    run_xfers(1);
    set_beat(0, 32'h40, 1'b1, 3'b010, 2'b10, 32'h1234_5678);
    set_beat(1, 32'h40, 1'b0, 3'b010, 2'b10, 32'h0);
    set_beat(2, 32'h41, 1'b1, 3'b000, 2'b10, 32'h0000_9900);
    set_beat(3, 32'h40, 1'b0, 3'b010, 2'b10, 32'h0);
    run_xfers(4);
    build_exp_rdy(4, 1);
    total++;
    if (rdy_log.size() != exp_rdy.size()) begin
      bad++; $display("FAIL bypass_len: got %0d want %0d", rdy_log.size(), exp_rdy.size());
    end else foreach (exp_rdy[k]) begin
      total++;
      if (rdy_log[k] !== exp_rdy[k]) begin bad++; $display("FAIL bypass_ready[%0d]: got %b want %b", k, rdy_log[k], exp_rdy[k]); end
    end
    total++;
    if (r_data[1] !== 32'h1234_5678) begin bad++; $display("FAIL bypass_word: got %h want 12345678", r_data[1]); end
    total++;
    if (r_data[3] !== 32'h1234_9978) begin bad++; $display("FAIL bypass_byte: got %h want 12349978", r_data[3]); end
  endtask

  task automatic test_errors();
    which = 0;
    set_beat(0, 32'h0, 1'b1, 3'b010, 2'b10, 32'h1111_1111);
    set_beat(1, 32'h4, 1'b1, 3'b010, 2'b10, 32'h2222_2222);
    run_xfers(2);
    set_beat(0, 32'h2, 1'b1, 3'b010, 2'b10, 32'hDEAD_BEEF);
    set_beat(1, 32'h4, 1'b1, 3'b011, 2'b10, 32'hDEAD_BEEF);
    set_beat(2, LIMIT, 1'b1, 3'b010, 2'b10, 32'hDEAD_BEEF);
    run_xfers(3);
    build_exp_rdy(3, 0);
    total++;
    if (rdy_log.size() != exp_rdy.size()) begin
      bad++; $display("FAIL err_len: got %0d want %0d", rdy_log.size(), exp_rdy.size());
    end else foreach (exp_rdy[k]) begin
      total++;
      if (rdy_log[k] !== exp_rdy[k]) begin bad++; $display("FAIL err_ready[%0d]: got %b want %b", k, rdy_log[k], exp_rdy[k]); end
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (r_resp[i] !== 2'b01) begin bad++; $display("FAIL err_resp[%0d]: got %b want 01", i, r_resp[i]); end
    end
    set_beat(0, 32'h0, 1'b0, 3'b010, 2'b10, 32'h0);
    set_beat(1, 32'h4, 1'b0, 3'b010, 2'b11, 32'h0);
    run_xfers(2);
    total++;
    if (r_data[0] !== 32'h1111_1111) begin bad++; $display("FAIL err_keep0: got %h want 11111111", r_data[0]); end
    total++;
    if (r_data[1] !== 32'h2222_2222) begin bad++; $display("FAIL err_keep4: got %h want 22222222", r_data[1]); end
  endtask

  task automatic test_reset_mid();
    which = 2;
    set_beat(0, 32'h80, 1'b1, 3'b010, 2'b10, 32'h0BAD_CAFE);
    run_xfers(1);
    hsel = 1'b1; haddr = 32'h80; htrans = 2'b10; hsize = 3'b010; hwrite = 1'b1;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h5555_AAAA;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    total++; if (hready !== 1'b0) begin bad++; $display("FAIL mid_inwait: got %b want 0", hready); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++; if (hready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", hready); end
    total++; if (hresp !== 2'b00) begin bad++; $display("FAIL mid_resp: got %b want 00", hresp); end
    @(posedge clk); #1 hwdata = '0;
    set_beat(0, 32'h80, 1'b0, 3'b010, 2'b10, 32'h0);
    run_xfers(1);
    total++;
    if (r_data[0] !== 32'h0BAD_CAFE) begin bad++; $display("FAIL mid_keep: got %h want 0badcafe", r_data[0]); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [2:0] s;
    int wi, r;
    which = 0;
    for (int i = 0; i < 16; i++) begin
      set_beat(i, 32'h400 + 32'(4*i), 1'b1, 3'b010, (i == 0) ? 2'b10 : 2'b11, $urandom);
      model[256 + i] = t_data[i];
    end
    run_xfers(16);
    for (int round = 0; round < 12; round++) begin
      for (int i = 0; i < 8; i++) begin
        wi = $urandom_range(0, 15);
        s = 3'($urandom_range(0, 2));
        a = 32'h400 + 32'(4*wi);
        if (s == 3'd0) a = a + 32'($urandom_range(0, 3));
        else if (s == 3'd1) a = a + 32'(2*$urandom_range(0, 1));
        r = $urandom_range(0, 9);
        if (r == 0) a = LIMIT + 32'(4*wi);
        else if (r == 1) begin s = 3'b010; a = 32'h400 + 32'(4*wi + $urandom_range(1, 3)); end
        else if (r == 2) s = 3'($urandom_range(3, 7));
        set_beat(i, a, 1'($urandom_range(0, 1)), s,
                 (i == 0 || $urandom_range(0, 1) == 0) ? 2'b10 : 2'b11, $urandom);
      end
      run_xfers(8);
      build_exp_rdy(8, 0);
      total++;
      if (rdy_log.size() != exp_rdy.size()) begin
        bad++; $display("FAIL rnd_len r%0d: got %0d want %0d", round, rdy_log.size(), exp_rdy.size());
      end else foreach (exp_rdy[k]) begin
        total++;
        if (rdy_log[k] !== exp_rdy[k]) begin bad++; $display("FAIL rnd_ready r%0d[%0d]: got %b want %b", round, k, rdy_log[k], exp_rdy[k]); end
      end
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
        if (!is_err(t_addr[i], t_size[i])) begin
          if (t_wr[i]) model[int'(t_addr[i] / 4)] = merge(model[int'(t_addr[i] / 4)], t_data[i], t_addr[i], t_size[i]);
          else exp_q.push_back(model[int'(t_addr[i] / 4)]);
        end
      end
      for (int i = 0; i < 8; i++) begin
        total++;
        if (r_resp[i] !== (is_err(t_addr[i], t_size[i]) ? 2'b01 : 2'b00)) begin
          bad++; $display("FAIL rnd_resp r%0d[%0d]: got %b for addr %h size %0d", round, i, r_resp[i], t_addr[i], t_size[i]);
        end
        if (!is_err(t_addr[i], t_size[i]) && !t_wr[i]) begin
          total++;
          if (r_data[i] !== exp_q[0]) begin bad++; $display("FAIL rnd_rdata r%0d[%0d]: got %h want %h", round, i, r_data[i], exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_lanes();
    test_bypass();
    test_errors();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
